arbiter_rr: RTL

Registered N-requester arbiter with selectable fixed-priority or round-robin policy, grant hold while the requester keeps requesting, and a bounded hold time that forces rotation. It is the sequential successor to the combinational daisy-chain arbiter. It sits between N bus masters and one shared resource, and presents a one-hot grant plus an encoded grant index.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/arbiter_rr_if.sv | 33 +++
 rtl/arb_pick.sv | 66 ++++++
 rtl/arbiter_rr.sv | 108 ++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the registered round-robin / fixed-priority arbiter.
//   MODE_FIXED / MODE_RR : arbitration policy selectors for the MODE parameter
//   arb_state_e          : two-state FSM encoding (idle / grant held)
//   clog2_min1()         : ceil(log2(v)) clamped to at least 1, used to size
//                          index and counter fields so N=1 or MAX_HOLD=0 still
//                          produce legal one-bit vectors
package arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between N bus masters and the arbiter.
//   req       : request vector, bit i = requester i (driven by the masters)
//   gnt       : one-hot grant or all zero
//   gnt_valid : |gnt
//   gnt_id    : index of the granted bit, holds its last value when idle
// Modports:
//   master : requester side (drives req, observes the grant)
//   slave  : arbiter side (samples req, drives the grant)
interface arbiter_rr_if import arb_pkg::*; #(
    parameter int N = 8
);
    localparam int IW = clog2_min1(N);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection.
//   req     : raw request vector
//   exclude : mask of requesters that may not win this round (current holder)
//   ptr     : round-robin start index (ignored in fixed-priority mode)
//   win     : one-hot winner, zero when nothing is eligible
//   win_id  : encoded winner index (0 when nothing is eligible)
//   any     : at least one eligible requester
// Both policies share one search: the eligible vector is doubled, the lower
// copy is masked below ptr, and the lowest set bit of the doubled vector is
// the winner. In fixed mode the mask is all ones, so the search reduces to
// plain lowest-index priority.
module arb_pick import arb_pkg::*; #(
    parameter int N    = 8,
    parameter int MODE = MODE_RR,
    localparam int IW  = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  exclude,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_id,
    output logic          any
);

    logic [N-1:0]   elig;
    logic [N-1:0]   thermo;
    logic [2*N-1:0] dbl;
    logic [IW:0]    pos;

    assign elig = req & ~exclude;
    assign any  = |elig;

    // thermo[i] = 1 for positions at or after the round-robin pointer
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_thermo
            if (MODE == MODE_RR) begin : g_rr
                assign thermo[gi] = (IW'(gi) >= ptr);
            end else begin : g_fixed
                assign thermo[gi] = 1'b1;
            end
        end
    endgenerate

    // Upper copy catches the wrap-around from N-1 back to 0.
    assign dbl = {elig, elig & thermo};

    // Scan from the top so the last hit written is the lowest set bit.
    always_comb begin
        pos = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos = (IW + 1)'(i);
            end
        end
    end

    assign win_id = (pos >= (IW + 1)'(N)) ? IW'(pos - (IW + 1)'(N)) : IW'(pos);

    generate
        for (gi = 0; gi < N; gi++) begin : g_win
            assign win[gi] = any && (win_id == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/arbiter_rr.sv
// Registered N-requester arbiter with fixed-priority or round-robin policy,
// grant hold while the holder keeps requesting, and a bounded hold time that
// forces rotation when other requesters are waiting.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : arbiter_rr_if slave modport (req in; gnt, gnt_valid, gnt_id out)
// Parameters:
//   N        : number of requesters (>= 1)
//   MODE     : MODE_FIXED (bit 0 highest) or MODE_RR
//   MAX_HOLD : max consecutive grant cycles while others wait, 0 = unlimited
// All outputs come straight from registers; req never reaches an output
// combinationally.
module arbiter_rr import arb_pkg::*; #(
    parameter int N        = 8,
    parameter int MODE     = MODE_RR,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    arbiter_rr_if.slave  bus
);

    localparam int IW = clog2_min1(N);
    localparam int HW = clog2_min1(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

    arb_state_e    state_reg;
    logic [N-1:0]  gnt_reg;
    logic          gnt_valid_reg;
    logic [IW-1:0] gnt_id_reg;
    logic [IW-1:0] ptr_reg;
    logic [HW-1:0] hold_cnt_reg;

    logic [N-1:0]  exclude;
    logic [N-1:0]  win;
    logic [IW-1:0] win_id;
    logic          win_any;
    logic          holder_req;
    logic          hold_full;
    logic          take_win;
    logic          go_idle;
    logic [IW-1:0] ptr_next;

    // While a grant is held the holder is masked out, so win_any means
    // "someone else is pending" and win is the re-arbitration result.
    // In IDLE nothing is masked and win_any is simply |req.
    assign exclude = (state_reg == ARB_GRANT) ? gnt_reg : '0;

    arb_pick #(
        .N    (N),
        .MODE (MODE)
    ) u_pick (
        .req     (bus.req),
        .exclude (exclude),
        .ptr     (ptr_reg),
        .win     (win),
        .win_id  (win_id),
        .any     (win_any)
    );

    assign holder_req = |(bus.req & gnt_reg);
    assign hold_full  = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIMIT);

    // A new holder is installed when idle with requests, when the holder
    // released, or when its hold budget ran out with a competitor waiting.
    assign take_win = win_any &&
                      ((state_reg == ARB_IDLE) || !holder_req || hold_full);
    assign go_idle  = (state_reg == ARB_GRANT) && !holder_req && !win_any;

    // Pointer moves just past the new winner, wrapping at N (not 2^IW).
    assign ptr_next = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ARB_IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            gnt_id_reg    <= '0;
            ptr_reg       <= '0;
            hold_cnt_reg  <= '0;
        end else if (take_win) begin
            state_reg     <= ARB_GRANT;
            gnt_reg       <= win;
            gnt_valid_reg <= 1'b1;
            gnt_id_reg    <= win_id;
            ptr_reg       <= ptr_next;
            hold_cnt_reg  <= HW'(1);
        end else if (go_idle) begin
            state_reg     <= ARB_IDLE;
            gnt_reg       <= '0;
            gnt_valid_reg <= 1'b0;
            hold_cnt_reg  <= '0;
        end else if (state_reg == ARB_GRANT) begin
            // Holder keeps the grant. Budget exhausted with no competitor:
            // restart the count rather than dropping the grant.
            if (hold_full) begin
                hold_cnt_reg <= HW'(1);
            end else if (MAX_HOLD != 0) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.gnt_id    = gnt_id_reg;

endmodule
